// File: rtl/sync_fifo_pf.sv
// sync_fifo_pf: parametrised single-clock FIFO with arbitrary depth,
// programmable almost-full/almost-empty thresholds, fill-level output,
// synchronous flush and optional first-word-fall-through read mode.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of pointers/level/status
//   wr_en, data_in      write request and data
//   rd_en               read request (FWFT: pop head)
//   afull_thresh        almostfull when level >= thresh
//   aempty_thresh       almostempty when level <= thresh
//   data_out, rd_valid  read data and its qualifier
//   wr_ack, overflow, underflow   registered outcome of last request
//   level               entry count 0..FIFO_DEPTH
//   full, empty, almostfull, almostempty   flags decoded from level
module sync_fifo_pf #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    localparam int PTR_W     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      afull_thresh,
    input  logic [CNT_W-1:0]      aempty_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_W-1:0]      level,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wa, ra;

    assign full        = (level_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (level_q == '0);
    assign almostfull  = (level_q >= afull_thresh);
    assign almostempty = (level_q <= aempty_thresh);
    assign level       = level_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // A read frees a slot in the same edge, so a full FIFO can still accept a write.
    assign ra = rd_en & ~empty;
    assign wa = wr_en & (~full | ra);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        wr_ack_d    = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wa) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (ra) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (wa && !ra) begin
                level_d = level_q + 1'b1;
            end else if (ra && !wa) begin
                level_d = level_q - 1'b1;
            end
            wr_ack_d    = wa;
            overflow_d  = wr_en & ~wa;
            underflow_d = rd_en & ~ra;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; rst_n gating keeps a write from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && wa && !flush) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else if (ra) begin
                    dout_q     <= mem_q[rd_ptr_q];
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b0;
                end
            end

            assign data_out = dout_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head is shown directly; zeroed when empty so reset reads back 0.
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_pf.sv
// tb_sync_fifo_pf: directed bench for sync_fifo_pf. Three instances:
// depth-8 standard mode, depth-5 standard mode (wrap), depth-8 FWFT.
module tb_sync_fifo_pf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // depth-8 standard instance
    logic        a_flush, a_wr_en, a_rd_en;
    logic [15:0] a_din, a_dout;
    logic [3:0]  a_afth, a_aeth, a_level;
    logic        a_rd_valid, a_wr_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;

    // depth-5 standard instance
    logic        b_flush, b_wr_en, b_rd_en;
    logic [15:0] b_din, b_dout;
    logic [2:0]  b_afth, b_aeth, b_level;
    logic        b_rd_valid, b_wr_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;

    // depth-8 FWFT instance
    logic        c_flush, c_wr_en, c_rd_en;
    logic [15:0] c_din, c_dout;
    logic [3:0]  c_afth, c_aeth, c_level;
    logic        c_rd_valid, c_wr_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;

    sync_fifo_pf #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .data_in(a_din),
        .rd_en(a_rd_en), .afull_thresh(a_afth), .aempty_thresh(a_aeth),
        .data_out(a_dout), .rd_valid(a_rd_valid), .wr_ack(a_wr_ack), .overflow(a_ovf),
        .underflow(a_udf), .level(a_level), .full(a_full), .empty(a_empty),
        .almostfull(a_af), .almostempty(a_ae));

    sync_fifo_pf #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .data_in(b_din),
        .rd_en(b_rd_en), .afull_thresh(b_afth), .aempty_thresh(b_aeth),
        .data_out(b_dout), .rd_valid(b_rd_valid), .wr_ack(b_wr_ack), .overflow(b_ovf),
        .underflow(b_udf), .level(b_level), .full(b_full), .empty(b_empty),
        .almostfull(b_af), .almostempty(b_ae));

    sync_fifo_pf #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_dutf (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr_en), .data_in(c_din),
        .rd_en(c_rd_en), .afull_thresh(c_afth), .aempty_thresh(c_aeth),
        .data_out(c_dout), .rd_valid(c_rd_valid), .wr_ack(c_wr_ack), .overflow(c_ovf),
        .underflow(c_udf), .level(c_level), .full(c_full), .empty(c_empty),
        .almostfull(c_af), .almostempty(c_ae));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_din = '0; a_afth = 4'd6; a_aeth = 4'd2;
        b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_din = '0; b_afth = 3'd5; b_aeth = 3'd0;
        c_flush = 0; c_wr_en = 0; c_rd_en = 0; c_din = '0; c_afth = 4'd8; c_aeth = 4'd0;
        rst_n = 0;
        // keep a write request active during reset: nothing may land
        a_wr_en = 1; a_din = 16'hDEAD;
        #22;
        checks++;
        if ({a_level, a_full, a_empty, a_af, a_ae, a_rd_valid, a_wr_ack, a_ovf, a_udf} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_flags: got lvl=%0d f=%b e=%b af=%b ae=%b v=%b ack=%b ov=%b un=%b, expected lvl=0 f=0 e=1 af=0 ae=1 others 0",
                     a_level, a_full, a_empty, a_af, a_ae, a_rd_valid, a_wr_ack, a_ovf, a_udf);
        end
        checks++;
        if (a_dout !== 16'h0000) begin
            errors++; $display("FAIL reset_data_out: got %h expected 0000", a_dout);
        end
        checks++;
        if ({c_level, c_empty, c_rd_valid, c_dout} !== {4'd0, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_fwft: got lvl=%0d e=%b v=%b d=%h, expected lvl=0 e=1 v=0 d=0000", c_level, c_empty, c_rd_valid, c_dout);
        end
        a_wr_en = 0;
        @(negedge clk);
        rst_n = 1;
        tick();
        checks++;
        if ({a_level, a_wr_ack} !== {4'd0, 1'b0}) begin
            errors++; $display("FAIL reset_release: got lvl=%0d ack=%b expected lvl=0 ack=0", a_level, a_wr_ack);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            a_wr_en = 1; a_din = 16'(i + 1);
            tick();
            checks++;
            if ({a_wr_ack, a_ovf, a_level, a_full} !== {1'b1, 1'b0, 4'(i + 1), (i == 7)}) begin
                errors++;
                $display("FAIL fill_%0d: got ack=%b ov=%b lvl=%0d full=%b expected ack=1 ov=0 lvl=%0d full=%b",
                         i, a_wr_ack, a_ovf, a_level, a_full, i + 1, (i == 7));
            end
        end
        a_din = 16'h0009;
        tick();
        checks++;
        if ({a_wr_ack, a_ovf, a_level, a_full} !== {1'b0, 1'b1, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL fill_overflow: got ack=%b ov=%b lvl=%0d full=%b expected ack=0 ov=1 lvl=8 full=1", a_wr_ack, a_ovf, a_level, a_full);
        end
        a_wr_en = 0;
        tick();
        checks++;
        if ({a_wr_ack, a_ovf} !== 2'b00) begin
            errors++; $display("FAIL overflow_clear: got ack=%b ov=%b expected 0 0", a_wr_ack, a_ovf);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            a_rd_en = 1;
            tick();
            checks++;
            if ({a_rd_valid, a_dout, a_level, a_empty} !== {1'b1, 16'(i + 1), 4'(7 - i), (i == 7)}) begin
                errors++;
                $display("FAIL drain_%0d: got v=%b d=%h lvl=%0d e=%b expected v=1 d=%h lvl=%0d e=%b",
                         i, a_rd_valid, a_dout, a_level, a_empty, 16'(i + 1), 7 - i, (i == 7));
            end
        end
        tick();
        checks++;
        if ({a_udf, a_rd_valid, a_dout, a_level} !== {1'b1, 1'b0, 16'h0008, 4'd0}) begin
            errors++;
            $display("FAIL drain_underflow: got un=%b v=%b d=%h lvl=%0d expected un=1 v=0 d=0008 lvl=0", a_udf, a_rd_valid, a_dout, a_level);
        end
        a_rd_en = 0;
    endtask

    task automatic test_back_to_back();
        a_wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            a_din = 16'h0010 + 16'(i);
            tick();
        end
        a_rd_en = 1; a_din = 16'h0020;
        tick();
        checks++;
        if ({a_wr_ack, a_ovf, a_level, a_full, a_rd_valid, a_dout} !== {1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 16'h0010}) begin
            errors++;
            $display("FAIL full_wr_rd: got ack=%b ov=%b lvl=%0d full=%b v=%b d=%h expected ack=1 ov=0 lvl=8 full=1 v=1 d=0010",
                     a_wr_ack, a_ovf, a_level, a_full, a_rd_valid, a_dout);
        end
        a_wr_en = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (a_dout !== ((i == 7) ? 16'h0020 : 16'h0011 + 16'(i))) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h expected %h", i, a_dout, ((i == 7) ? 16'h0020 : 16'h0011 + 16'(i)));
            end
        end
        a_wr_en = 1; a_din = 16'h0030;
        tick();
        checks++;
        if ({a_wr_ack, a_udf, a_level, a_rd_valid} !== {1'b1, 1'b1, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL empty_wr_rd: got ack=%b un=%b lvl=%0d v=%b expected ack=1 un=1 lvl=1 v=0", a_wr_ack, a_udf, a_level, a_rd_valid);
        end
        a_wr_en = 0;
        tick();
        checks++;
        if ({a_dout, a_level, a_rd_valid} !== {16'h0030, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL empty_wr_rd_read: got d=%h lvl=%0d v=%b expected d=0030 lvl=0 v=1", a_dout, a_level, a_rd_valid);
        end
        a_rd_en = 0;
    endtask

    task automatic test_thresh_flush();
        a_wr_en = 1;
        for (int i = 0; i < 6; i++) begin
            a_din = 16'h0040 + 16'(i);
            tick();
            checks++;
            if ({a_af, a_ae} !== {(i + 1 >= 6), (i + 1 <= 2)}) begin
                errors++;
                $display("FAIL thresh_%0d: got af=%b ae=%b expected af=%b ae=%b", i, a_af, a_ae, (i + 1 >= 6), (i + 1 <= 2));
            end
        end
        a_flush = 1; a_rd_en = 1; a_din = 16'h00FF;
        tick();
        checks++;
        if ({a_level, a_empty, a_ae, a_af, a_wr_ack, a_ovf, a_udf, a_rd_valid} !== {4'd0, 1'b1, 1'b1, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL flush_state: got lvl=%0d e=%b ae=%b af=%b ack=%b ov=%b un=%b v=%b expected lvl=0 e=1 ae=1 af=0 rest 0",
                     a_level, a_empty, a_ae, a_af, a_wr_ack, a_ovf, a_udf, a_rd_valid);
        end
        checks++;
        if (a_dout !== 16'h0030) begin
            errors++; $display("FAIL flush_hold_data: got %h expected 0030", a_dout);
        end
        a_flush = 0; a_rd_en = 0; a_din = 16'h0055;
        tick();
        a_wr_en = 0; a_rd_en = 1;
        tick();
        checks++;
        if ({a_dout, a_rd_valid, a_level} !== {16'h0055, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL post_flush_rw: got d=%h v=%b lvl=%0d expected d=0055 v=1 lvl=0", a_dout, a_rd_valid, a_level);
        end
        a_rd_en = 0;
        a_afth = 4'd0; a_aeth = 4'd0;
        #1;
        checks++;
        if ({a_af, a_ae} !== 2'b11) begin
            errors++; $display("FAIL thresh_comb: got af=%b ae=%b expected 1 1", a_af, a_ae);
        end
        a_afth = 4'd6; a_aeth = 4'd2;
    endtask

    task automatic test_wrap();
        b_wr_en = 1;
        for (int i = 0; i < 5; i++) begin
            b_din = 16'h0100 + 16'(i);
            tick();
        end
        checks++;
        if ({b_level, b_full, b_af} !== {3'd5, 1'b1, 1'b1}) begin
            errors++; $display("FAIL wrap_prefill: got lvl=%0d full=%b af=%b expected 5 1 1", b_level, b_full, b_af);
        end
        b_rd_en = 1;
        for (int i = 0; i < 13; i++) begin
            b_din = 16'h0105 + 16'(i);
            tick();
            checks++;
            if ({b_dout, b_rd_valid, b_wr_ack, b_ovf, b_level} !== {16'h0100 + 16'(i), 1'b1, 1'b1, 1'b0, 3'd5}) begin
                errors++;
                $display("FAIL wrap_pair_%0d: got d=%h v=%b ack=%b ov=%b lvl=%0d expected d=%h v=1 ack=1 ov=0 lvl=5",
                         i, b_dout, b_rd_valid, b_wr_ack, b_ovf, b_level, 16'h0100 + 16'(i));
            end
        end
        b_wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({b_dout, b_level} !== {16'h010D + 16'(i), 3'(4 - i)}) begin
                errors++;
                $display("FAIL wrap_drain_%0d: got d=%h lvl=%0d expected d=%h lvl=%0d", i, b_dout, b_level, 16'h010D + 16'(i), 4 - i);
            end
        end
        b_rd_en = 0;
        checks++;
        if ({b_empty, b_ae} !== 2'b11) begin
            errors++; $display("FAIL wrap_empty: got e=%b ae=%b expected 1 1", b_empty, b_ae);
        end
    endtask

    task automatic test_fwft();
        c_wr_en = 1; c_din = 16'hABCD;
        tick();
        c_wr_en = 0;
        checks++;
        if ({c_dout, c_rd_valid, c_level} !== {16'hABCD, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL fwft_show: got d=%h v=%b lvl=%0d expected d=abcd v=1 lvl=1", c_dout, c_rd_valid, c_level);
        end
        c_wr_en = 1; c_din = 16'h1234;
        tick();
        c_wr_en = 0;
        checks++;
        if ({c_dout, c_level} !== {16'hABCD, 4'd2}) begin
            errors++; $display("FAIL fwft_hold_head: got d=%h lvl=%0d expected d=abcd lvl=2", c_dout, c_level);
        end
        c_rd_en = 1;
        tick();
        checks++;
        if ({c_dout, c_rd_valid, c_level} !== {16'h1234, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL fwft_pop1: got d=%h v=%b lvl=%0d expected d=1234 v=1 lvl=1", c_dout, c_rd_valid, c_level);
        end
        tick();
        c_rd_en = 0;
        checks++;
        if ({c_empty, c_rd_valid, c_level} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL fwft_pop2: got e=%b v=%b lvl=%0d expected e=1 v=0 lvl=0", c_empty, c_rd_valid, c_level);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_thresh_flush();
        test_wrap();
        test_fwft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
